// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: FSM state encoding and forward-select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    MEM_ABORT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forward selector: picks M-stage, W-stage or register-file value.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  // Younger producer (M) has priority over older (W); x0 never forwards.
  always_comb begin
    fwd_o = FWD_REG;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/branch control, memory-wait FSM.
// Define HAZARD_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       MemAckM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [DATA_WIDTH-1:0] stall_cnt,
  output logic [DATA_WIDTH-1:0] flush_cnt
`endif
);

  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  // The request cycle in RUN is the first stall cycle, so the wait ends after MEM_TIMEOUT-1 more.
  localparam logic [CNT_W-1:0] ABORT_AT = CNT_W'(MEM_TIMEOUT - 2);

  if (DATA_WIDTH < 1 || MEM_TIMEOUT < 2) begin : g_bad_cfg
    $error("hazard_ctrl: DATA_WIDTH must be >= 1 and MEM_TIMEOUT >= 2");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             mem_err_q;
  logic             br_pend_q, br_pend_d;
  logic             load_use, mem_miss, branch;

  fwd_sel u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardAE)
  );

  fwd_sel u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (ForwardBE)
  );

  assign load_use = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_miss = MemReqM && !MemAckM;
  // A branch seen while frozen is remembered and flushed once RUN resumes.
  assign branch   = PCSrcE || br_pend_q;

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    br_pend_d = br_pend_q;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    unique case (state_q)
      RUN: begin
        tmo_d     = '0;
        br_pend_d = 1'b0;
        if (mem_miss) begin
          state_d   = MEM_WAIT;
          br_pend_d = branch;
          {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
        end else if (branch) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        br_pend_d = br_pend_q || PCSrcE;
        if (MemAckM) begin
          state_d = RUN;
        end else begin
          {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
          tmo_d = tmo_q + CNT_W'(1);
          if (tmo_q == ABORT_AT) state_d = MEM_ABORT;
        end
      end
      MEM_ABORT: begin
        br_pend_d = br_pend_q || PCSrcE;
        FlushW    = 1'b1;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      {StallF, StallD, StallE, StallM} = 4'b0000;
      {FlushD, FlushE, FlushW}         = 3'b111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      tmo_q     <= '0;
      mem_err_q <= 1'b0;
      br_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      br_pend_q <= br_pend_d;
      if (state_d == MEM_ABORT) mem_err_q <= 1'b1;
    end
  end

  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
  logic [DATA_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF) stall_cnt_q <= stall_cnt_q + DATA_WIDTH'(1);
      if (FlushE) flush_cnt_q <= flush_cnt_q + DATA_WIDTH'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl; expected output vectors are queued per cycle and popped at sample time.
module tb_hazard_ctrl;

  localparam int DW = 32;
  localparam int MT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
`ifdef HAZARD_PERF_EN
  logic [DW-1:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.DATA_WIDTH(DW), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs;
  logic [11:0] e;

  // {FwdA, FwdB, StallF/D/E/M, FlushD/E/W, mem_err}
  assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err};

  function automatic logic [11:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [3:0] st, input logic [2:0] fl, input logic me);
    return {fa, fb, st, fl, me};
  endfunction

  localparam logic [3:0] NOST = 4'b0000, ALLST = 4'b1111, LUST = 4'b1100;

  task automatic idle_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemAckM} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b111, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset: got %b want %b", obs, e); end
    tick();
    rst = 1'b0;
    exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release: got %b want %b", obs, e); end
    tick();
  endtask

  task automatic test_forward();
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      case (i)
        0: begin Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
                 exp_q.push_back(mk(2'b10, 2'b00, NOST, 3'b000, 1'b0)); end
        1: begin Rs1E = 5; RdM = 0; RegWriteM = 1; RdW = 5; RegWriteW = 1;
                 exp_q.push_back(mk(2'b01, 2'b00, NOST, 3'b000, 1'b0)); end
        2: begin Rs1E = 5; RdM = 5; RegWriteM = 0; RdW = 5; RegWriteW = 0;
                 exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0)); end
        3: begin Rs1E = 4; Rs2E = 9; RdM = 9; RegWriteM = 1; RdW = 9; RegWriteW = 1;
                 exp_q.push_back(mk(2'b00, 2'b10, NOST, 3'b000, 1'b0)); end
        4: begin Rs1E = 9; Rs2E = 9; RdM = 9; RegWriteM = 0; RdW = 9; RegWriteW = 1;
                 exp_q.push_back(mk(2'b01, 2'b01, NOST, 3'b000, 1'b0)); end
        default: begin Rs1E = 0; Rs2E = 0; RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1;
                 exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0)); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL forward[%0d]: got %b want %b", i, obs, e); end
      tick();
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      case (i)
        0: begin ResultSrcE = 1; RdE = 7; Rs2D = 7; exp_q.push_back(mk(2'b00, 2'b00, LUST, 3'b010, 1'b0)); end
        1: begin RdE = 7; Rs2D = 7; exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0)); end
        2: begin ResultSrcE = 1; RdE = 0; Rs1D = 0; exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0)); end
        default: begin ResultSrcE = 1; RdE = 7; Rs1D = 7; exp_q.push_back(mk(2'b00, 2'b00, LUST, 3'b010, 1'b0)); end
      endcase
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL load_use[%0d]: got %b want %b", i, obs, e); end
      tick();
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 2; i++) begin
      idle_inputs();
      if (i == 0) begin
        ResultSrcE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b110, 1'b0));
      end else begin
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0));
      end
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL branch[%0d]: got %b want %b", i, obs, e); end
      tick();
    end
  endtask

  // Three-cycle memory wait with a branch arriving mid-wait; its flush follows the exit.
  task automatic test_mem_wait();
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (i < 3) begin
        MemReqM = 1; PCSrcE = (i == 1); ResultSrcE = 1; RdE = 3; Rs1D = 3;
        exp_q.push_back(mk(2'b00, 2'b00, ALLST, 3'b001, 1'b0));
      end else if (i == 3) begin
        MemReqM = 1; MemAckM = 1;
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0));
      end else if (i == 4) begin
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b110, 1'b0));
      end else begin
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0));
      end
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL mem_wait[%0d]: got %b want %b", i, obs, e); end
      tick();
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 22; i++) begin
      idle_inputs();
      rst = 1'b0;
      if (i < MT) begin
        MemReqM = 1;
        exp_q.push_back(mk(2'b00, 2'b00, ALLST, 3'b001, 1'b0));
      end else if (i == MT) begin
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b001, 1'b1));
      end else if (i < MT + 4) begin
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b1));
      end else if (i == MT + 4) begin
        rst = 1'b1;
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b111, 1'b1));
      end else begin
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0));
      end
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout[%0d]: got %b want %b", i, obs, e); end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_rst_mid_wait();
    for (int i = 0; i < 5 + 1 + MT + 2; i++) begin
      idle_inputs();
      rst = 1'b0;
      if (i < 5) begin
        MemReqM = 1;
        exp_q.push_back(mk(2'b00, 2'b00, ALLST, 3'b001, 1'b0));
      end else if (i == 5) begin
        rst = 1'b1; MemReqM = 1;
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b111, 1'b0));
      end else begin
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0));
      end
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL rst_mid_wait[%0d]: got %b want %b", i, obs, e); end
      tick();
    end
    rst = 1'b0;
  endtask

  // Single-cycle memory hits back to back, then a hit overlapping a load-use.
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      MemReqM = (i < 3); MemAckM = (i < 3);
      if (i == 2) begin
        ResultSrcE = 1; RdE = 12; Rs1D = 12;
        exp_q.push_back(mk(2'b00, 2'b00, LUST, 3'b010, 1'b0));
      end else begin
        exp_q.push_back(mk(2'b00, 2'b00, NOST, 3'b000, 1'b0));
      end
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, e); end
      tick();
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      if (i < 2) begin ResultSrcE = 1; RdE = 7; Rs2D = 7; end
      else if (i >= 3 && i < 6) MemReqM = 1;
      else if (i == 6) begin MemReqM = 1; MemAckM = 1; end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (stall_cnt !== DW'(5)) begin errors++; $display("FAIL perf_stall_cnt: got %0d want 5", stall_cnt); end
    checks++;
    if (flush_cnt !== DW'(2)) begin errors++; $display("FAIL perf_flush_cnt: got %0d want 2", flush_cnt); end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_rst_mid_wait();
    test_back_to_back();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, counter width; MEM_TIMEOUT, 16, max memory wait cycles before abort.
REQ-002 SHALL have ports (one clock; reset synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- Rs1D, Rs2D  in  5  decode-stage source registers
- Rs1E, Rs2E, RdE  in  5  execute-stage registers
- RdM, RdW  in  5  memory/writeback destination registers
- RegWriteM, RegWriteW  in  1  register-write enables
- ResultSrcE  in  1  execute instruction is a load
- PCSrcE  in  1  branch/jump taken in execute
- MemReqM  in  1  load/store in memory stage
- MemAckM  in  1  data memory completes access
- ForwardAE, ForwardBE  out  2  operand forward selects
- StallF, StallD, StallE, StallM  out  1  hold stage registers
- FlushD, FlushE, FlushW  out  1  insert bubble into stage register
- mem_err  out  1  sticky memory timeout flag
- stall_cnt, flush_cnt  out  DATA_WIDTH  performance counters (HAZARD_PERF_EN only)

Function
REQ-003 ForwardAE SHALL be 2'b10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 2'b01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 2'b00; ForwardBE identical using Rs2E.
REQ-004 Forward selects SHALL be combinational, zero-latency, and M-stage match SHALL win over W-stage match.
REQ-005 Load-use hazard SHALL be ResultSrcE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-006 FSM states SHALL be RUN, MEM_WAIT, MEM_ABORT.
REQ-007 RUN: if MemReqM && !MemAckM, next state MEM_WAIT; timeout counter cleared; otherwise stay RUN.
REQ-008 MEM_WAIT: StallF, StallD, StallE, StallM = 1, FlushW = 1, FlushD = FlushE = 0, regardless of load-use or PCSrcE.
REQ-009 MEM_WAIT: MemAckM=1 -> RUN next cycle, stalls drop the same cycle ack is seen (combinational on MemAckM).
REQ-010 MEM_WAIT: timeout counter increments each cycle; reaching MEM_TIMEOUT without ack -> MEM_ABORT.
REQ-011 MEM_ABORT: lasts exactly one cycle; mem_err set (sticky until rst); FlushW=1, no stalls; next state RUN.
REQ-012 RUN with PCSrcE=1: FlushD=1, FlushE=1 for that cycle; StallF=StallD=0 (branch overrides load-use).
REQ-013 RUN with load-use and PCSrcE=0: StallF=StallD=1, FlushE=1 for exactly one cycle.
REQ-014 MemReqM with MemAckM=1 in RUN SHALL cause no stall (single-cycle memory path).
REQ-015 A branch held in E during MEM_WAIT SHALL produce its flush in the first RUN cycle after exit.

Reset
REQ-016 While rst=1: state RUN, timeout counter 0, mem_err 0, all Stall* 0, FlushD=FlushE=FlushW=1.
REQ-017 rst asserted during MEM_WAIT SHALL abandon the wait without setting mem_err.

Configuration
REQ-018 With HAZARD_PERF_EN defined: stall_cnt increments on every cycle StallF=1, flush_cnt on every cycle FlushE=1; both reset to 0, wrap modulo 2^DATA_WIDTH.
REQ-019 Without HAZARD_PERF_EN: stall_cnt/flush_cnt ports and counters absent; all other behaviour identical.

Structure
REQ-020 Package hazard_pkg SHALL hold the state enum (RUN, MEM_WAIT, MEM_ABORT) and forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
REQ-021 Sub-module fwd_sel (single operand comparator) SHALL be instantiated twice, for A and B.

Verification
REQ-022 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=2'b10; RdM=0 instead -> ForwardAE=2'b01.
REQ-023 ResultSrcE=1, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for one cycle, then 0.
REQ-024 Load-use (RdE=7, Rs1D=7) with PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
REQ-025 MemReqM=1, MemAckM low 3 cycles then high -> Stall F/D/E/M and FlushW high 3 cycles, RUN on ack, mem_err=0.
REQ-026 MemReqM=1, MemAckM never -> 16 stall cycles, one MEM_ABORT cycle, mem_err=1 until rst; rst mid-wait -> mem_err stays 0.
REQ-027 HAZARD_PERF_EN build: 2 load-use stalls plus one 3-cycle memory wait -> stall_cnt=5.
